// File: rtl/sum_accumulator.sv
// Accumulates BEATS signed partial sums plus a bias into one saturated
// neuron pre-activation value, presented on a valid/ready output.
module sum_accumulator #(
   parameter int WIDTH = 32,
   parameter int BEATS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_valid,
   output logic                    i_ready,
   input  logic signed [WIDTH-1:0] i,
   input  logic signed [WIDTH-1:0] i_bias,
   output logic                    o_valid,
   input  logic                    o_ready,
   output logic signed [WIDTH-1:0] o,
   output logic                    o_ovf
);

   localparam int AW = WIDTH + 9;
   localparam logic [8:0] LAST = 9'(BEATS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam logic signed [AW-1:0] SAT_MAX = {{10{1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{10{1'b1}}, {(WIDTH-1){1'b0}}};

   logic [1:0]              state;
   logic [8:0]              cnt;
   logic signed [AW-1:0]    acc;

   logic signed [AW-1:0]    i_ext;
   logic signed [AW-1:0]    bias_ext;
   logic signed [AW-1:0]    acc_next;
   logic [8:0]              cnt_next;
   logic                    last_beat;
   logic signed [WIDTH-1:0] sat_o;
   logic                    sat_ovf;

   assign i_ext    = {{9{i[WIDTH-1]}}, i};
   assign bias_ext = {{9{i_bias[WIDTH-1]}}, i_bias};

   assign i_ready = (state != HOLD);
   assign o_valid = (state == HOLD);

   // The first beat of a result restarts the sum from the bias.
   always_comb begin
      acc_next = acc + i_ext;
      cnt_next = cnt + 9'd1;
      if (state == IDLE) begin
         acc_next = bias_ext + i_ext;
         cnt_next = 9'd1;
      end
   end

   assign last_beat = (cnt_next == LAST);

   always_comb begin
      sat_o   = acc_next[WIDTH-1:0];
      sat_ovf = 1'b0;
      if (acc_next > SAT_MAX) begin
         sat_o   = {1'b0, {(WIDTH-1){1'b1}}};
         sat_ovf = 1'b1;
      end else if (acc_next < SAT_MIN) begin
         sat_o   = {1'b1, {(WIDTH-1){1'b0}}};
         sat_ovf = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         o     <= '0;
         o_ovf <= 1'b0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (i_valid) begin
                  acc <= acc_next;
                  cnt <= cnt_next;
                  if (last_beat) begin
                     state <= HOLD;
                     o     <= sat_o;
                     o_ovf <= sat_ovf;
                  end else begin
                     state <= ACC;
                  end
               end
            end
            HOLD: begin
               if (o_ready) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed-vector bench for sum_accumulator: a BEATS=4 instance driven from a
// vector table plus corner sequences, and a BEATS=1 instance for back-to-back use.
module tb_sum_accumulator;

   typedef struct {
      string       name;
      logic [31:0] bias;
      logic [31:0] beat [4];
      int          gap  [4];
      logic [31:0] exp_o;
      logic        exp_ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready;
   logic [31:0] i = '0;
   logic [31:0] i_bias = '0;
   logic        o_valid;
   logic        o_ready = 1'b0;
   logic [31:0] o;
   logic        o_ovf;

   logic        v1 = 1'b0;
   logic        r1;
   logic [31:0] i1 = '0;
   logic [31:0] b1 = '0;
   logic        ov1;
   logic [31:0] o1;
   logic        ovf1;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs [8];

   always #5 clk = ~clk;

   sum_accumulator #(.WIDTH(32), .BEATS(4)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i(i),
      .i_bias(i_bias), .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_ovf(o_ovf)
   );

   sum_accumulator #(.WIDTH(32), .BEATS(1)) dut1 (
      .clk(clk), .rst(rst), .i_valid(v1), .i_ready(r1), .i(i1),
      .i_bias(b1), .o_valid(ov1), .o_ready(1'b1), .o(o1), .o_ovf(ovf1)
   );

   function automatic vec_t mkVec(string n, logic [31:0] b, logic [31:0] x0,
                                  logic [31:0] x1, logic [31:0] x2, logic [31:0] x3,
                                  int g1, int g2, int g3, logic [31:0] e, logic ov);
      vec_t v;
      v.name = n;
      v.bias = b;
      v.beat[0] = x0; v.beat[1] = x1; v.beat[2] = x2; v.beat[3] = x3;
      v.gap[0] = 0;   v.gap[1] = g1;  v.gap[2] = g2;  v.gap[3] = g3;
      v.exp_o = e;
      v.exp_ovf = ov;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Later beats drive bias=99 to show the bias is only sampled on the first beat.
   task automatic applyStimulus(input vec_t v);
      for (int k = 0; k < 4; k++) begin
         i_bias = 32'd99;
         repeat (v.gap[k]) begin
            tick();
            checkOutput({v.name, "_gap_valid"}, {31'b0, o_valid}, 32'd0);
         end
         checkOutput({v.name, "_ready"}, {31'b0, i_ready}, 32'd1);
         i_valid = 1'b1;
         i = v.beat[k];
         i_bias = (k == 0) ? v.bias : 32'd99;
         tick();
         i_valid = 1'b0;
         checkOutput({v.name, "_valid"}, {31'b0, o_valid}, (k == 3) ? 32'd1 : 32'd0);
      end
      checkOutput({v.name, "_o"}, o, v.exp_o);
      checkOutput({v.name, "_ovf"}, {31'b0, o_ovf}, {31'b0, v.exp_ovf});
      checkOutput({v.name, "_hold_ready"}, {31'b0, i_ready}, 32'd0);
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      checkOutput({v.name, "_done_valid"}, {31'b0, o_valid}, 32'd0);
      checkOutput({v.name, "_done_ready"}, {31'b0, i_ready}, 32'd1);
   endtask

   initial begin
      vecs[0] = mkVec("basic", 32'd10, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 0, 32'd20, 1'b0);
      vecs[1] = mkVec("neg_gaps", 32'd3, -32'sd5, -32'sd5, -32'sd5, -32'sd5, 1, 3, 2,
                      32'hFFFF_FFEF, 1'b0);
      vecs[2] = mkVec("sat_pos", 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                      32'h7FFF_FFFF, 0, 0, 0, 32'h7FFF_FFFF, 1'b1);
      vecs[3] = mkVec("sat_neg", 32'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                      32'h8000_0000, 0, 0, 0, 32'h8000_0000, 1'b1);
      vecs[4] = mkVec("max_exact", 32'd0, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0,
                      0, 0, 0, 32'h7FFF_FFFF, 1'b0);
      vecs[5] = mkVec("min_exact", 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0,
                      0, 0, 0, 32'h8000_0000, 1'b0);
      vecs[6] = mkVec("max_plus1", 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0,
                      0, 0, 0, 32'h7FFF_FFFF, 1'b1);
      vecs[7] = mkVec("wide_cancel", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                      32'h8000_0000, 32'd1, 0, 0, 0, 32'hFFFF_FFFF, 1'b0);

      tick();
      tick();
      checkOutput("rst_valid", {31'b0, o_valid}, 32'd0);
      checkOutput("rst_o", o, 32'd0);
      checkOutput("rst_ovf", {31'b0, o_ovf}, 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("rst_ready", {31'b0, i_ready}, 32'd1);

      for (int n = 0; n < 8; n++) applyStimulus(vecs[n]);

      // Backpressure: 4 beats of 1 give 4, then 7 is held on the input during HOLD.
      applyStimulus(mkVec("bp_pre", 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 0, 0, 0, 32'd4, 1'b0));
      for (int k = 0; k < 4; k++) begin
         i_valid = 1'b1; i = 32'd1; i_bias = 32'd0;
         tick();
      end
      i = 32'd7;
      for (int k = 0; k < 6; k++) begin
         checkOutput("bp_valid", {31'b0, o_valid}, 32'd1);
         checkOutput("bp_o", o, 32'd4);
         checkOutput("bp_ovf", {31'b0, o_ovf}, 32'd0);
         checkOutput("bp_ready", {31'b0, i_ready}, 32'd0);
         tick();
      end
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      checkOutput("bp_release_valid", {31'b0, o_valid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         checkOutput("bp_next_ready", {31'b0, i_ready}, 32'd1);
         tick();
         checkOutput("bp_next_valid", {31'b0, o_valid}, (k == 3) ? 32'd1 : 32'd0);
      end
      i_valid = 1'b0;
      checkOutput("bp_next_o", o, 32'd28);
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;

      // Reset in the middle of a result discards the two accepted beats.
      i_valid = 1'b1; i_bias = 32'd100; i = 32'd50;
      tick();
      i_bias = 32'd0;
      tick();
      i_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_valid", {31'b0, o_valid}, 32'd0);
      checkOutput("mid_rst_ready", {31'b0, i_ready}, 32'd1);
      applyStimulus(mkVec("after_rst", 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 0, 0, 0, 32'd4, 1'b0));

      // Single-beat build: one result every two cycles with i_valid held high.
      v1 = 1'b1; b1 = 32'hFFFF_FFFE; i1 = 32'd5;
      for (int k = 0; k < 4; k++) begin
         checkOutput("b1_ready", {31'b0, r1}, 32'd1);
         tick();
         checkOutput("b1_valid", {31'b0, ov1}, 32'd1);
         checkOutput("b1_o", o1, 32'd3 + 32'(k));
         checkOutput("b1_hold_ready", {31'b0, r1}, 32'd0);
         i1 = 32'd6 + 32'(k);
         tick();
         checkOutput("b1_idle_valid", {31'b0, ov1}, 32'd0);
      end
      v1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the N-input adder tree in the neuron datapath.
- When a neuron's fan-in exceeds one adder tree, the tree emits one signed partial sum per beat. This block accumulates BEATS such partial sums plus a bias into one neuron pre-activation value.
- It saturates the result to WIDTH bits and presents it on a valid/ready output to the activation stage.

Parameters:
- WIDTH, 32: bit width of the partial-sum input, bias and result; two's-complement signed.
- BEATS, 4: number of partial sums accepted per result; legal range is 1 to 256.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  partial sum on i is valid.
- i_ready  output  1  block can accept a partial sum this cycle.
- i  input  WIDTH  signed partial sum from the adder tree.
- i_bias  input  WIDTH  signed bias; sampled only on the first beat of a result.
- o_valid  output  1  result on o is valid.
- o_ready  input  1  downstream accepts the result.
- o  output  WIDTH  signed, saturated accumulated result.
- o_ovf  output  1  result was clamped; qualified by o_valid.

Behaviour:
- Reset: rst is synchronous and active-high; the block has one clock, clk.
  - While rst=1, state goes to IDLE and the beat counter to 0.
  - The internal accumulator, o and o_ovf go to 0; o_valid goes to 0.
  - i_ready is 1 in the cycle after reset is released.
  - Reset asserted mid-result discards all partial state; no result is emitted.
- Accepted beat: a cycle with i_valid=1 and i_ready=1. No other cycle changes the accumulator or the counter.
- Internal accumulator: signed, width WIDTH+9, so 256 full-scale beats plus the bias cannot wrap internally.
- i and i_bias: sign-extended to the accumulator width before use.
- States:
  - IDLE: i_ready=1, o_valid=0.
    - On an accepted beat: acc <= i_bias + i and cnt <= 1.
    - If BEATS=1, go to HOLD; otherwise go to ACC.
  - ACC: i_ready=1, o_valid=0.
    - On an accepted beat: acc <= acc + i and cnt <= cnt+1.
    - When the beat makes cnt equal BEATS, go to HOLD.
    - Idle cycles (i_valid=0) hold all state.
  - HOLD: i_ready=0, o_valid=1.
    - o and o_ovf are registered on the transition into HOLD and stay stable until the handshake.
    - On o_ready=1, go to IDLE and cnt <= 0.
- Output saturation, computed once when entering HOLD:
  - acc > 2^(WIDTH-1)-1: o = 2^(WIDTH-1)-1, o_ovf = 1.
  - acc < -2^(WIDTH-1): o = -2^(WIDTH-1), o_ovf = 1.
  - Otherwise o = acc[WIDTH-1:0], o_ovf = 0.
- Latency: the last beat is accepted at edge t; o_valid=1 in the cycle after edge t.
  - The earliest next first-beat acceptance is the cycle after the o handshake.
  - Throughput is therefore BEATS+1 cycles per result with no backpressure.
- No overlap: i_ready=0 in HOLD, so a beat presented during HOLD is not consumed and the upstream must hold it.
- Handshake rules:
  - o_valid is never deasserted without o_ready while in HOLD.
  - o_valid does not depend combinationally on o_ready.
  - i_ready is a decode of state only, with no combinational path from i_valid.
- o and o_ovf keep their last values after the handshake; downstream must ignore them while o_valid=0.
- Simultaneous rst and any handshake: rst wins.

Test Plan:
- Basic sum: WIDTH=32, BEATS=4, bias=10, beats 1,2,3,4 on consecutive cycles, o_ready=1.
  -> o_valid=1 exactly one cycle after the 4th beat, o=20, o_ovf=0, then i_ready=1 again.
- Negative values with gaps: bias=3, beats of -5 separated by 0–3 cycles of i_valid=0.
  -> o=-17 (0xFFFFFFEF), o_ovf=0; bias driven to 99 on later beats has no effect.
- Saturation: bias=0, four beats of 0x7FFFFFFF -> o=0x7FFFFFFF, o_ovf=1.
  - Four beats of 0x80000000 -> o=0x80000000, o_ovf=1.
  - Beats 0x7FFFFFFF,1,-1,0 -> o=0x7FFFFFFF, o_ovf=0.
- Backpressure: hold o_ready=0 for 6 cycles after o_valid rises, with i_valid=1 and i=7 held throughout.
  -> o, o_valid and o_ovf are stable; i_ready=0 and no beat is consumed; after o_ready=1 the next result counts 7 from its first accepted beat.
- Reset mid-operation: accept 2 beats (bias=100, i=50,50), pulse rst for 1 cycle, then send bias=0 with beats 1,1,1,1.
  -> no o_valid before the new result; o=4.
- BEATS=1 build: bias=-2, i=5 -> o=3 one cycle later; back-to-back results every 2 cycles with o_ready tied to 1.
